// File: rtl/ex_muldiv_sequencer.sv
// Iterative unsigned multiply/divide unit for the execute stage: shift-add multiply,
// restoring divide, one bit per cycle, with pipeline stall and flush handling.
module ex_muldiv_sequencer #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] src_a_i,
    input  logic [WIDTH-1:0] src_b_i,
    input  logic             flush_i,
    output logic             stall_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_e;

    typedef enum logic [1:0] {
        OP_MUL   = 2'b00,
        OP_MULHU = 2'b01,
        OP_DIVU  = 2'b10,
        OP_REMU  = 2'b11
    } op_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    op_e              op_q, op_d;
    logic [WIDTH-1:0] acc_q, acc_d;      // product high word, or partial remainder
    logic [WIDTH-1:0] lo_q, lo_d;        // multiplier -> product low word, or dividend -> quotient
    logic [WIDTH-1:0] opd_q, opd_d;      // multiplicand, or divisor
    logic [WIDTH-1:0] result_q, result_d;

    logic             is_div;
    logic             last_iter;

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] mul_acc_nx;
    logic [WIDTH-1:0] mul_lo_nx;

    logic [WIDTH:0]   div_shift;
    logic             div_ge;
    logic [WIDTH-1:0] div_diff;
    logic [WIDTH-1:0] div_acc_nx;
    logic [WIDTH-1:0] div_lo_nx;

    logic [WIDTH-1:0] iter_acc;
    logic [WIDTH-1:0] iter_lo;
    logic [WIDTH-1:0] final_result;

    assign is_div    = op_q[1];
    assign last_iter = (cnt_q == CNT_W'(WIDTH - 1));

    // Shift-add multiply: add multiplicand into the high word when the current
    // multiplier LSB is set, then shift the {carry, high, low} chain right by one.
    assign mul_sum    = {1'b0, acc_q} + (lo_q[0] ? {1'b0, opd_q} : '0);
    assign mul_acc_nx = mul_sum[WIDTH:1];
    assign mul_lo_nx  = {mul_sum[0], lo_q[WIDTH-1:1]};

    // Restoring divide: the remainder stays below the divisor, so the WIDTH-bit
    // difference is exact whenever the WIDTH+1-bit compare allows the subtract.
    // A zero divisor always subtracts, giving an all-ones quotient and remainder = dividend.
    assign div_shift  = {acc_q, lo_q[WIDTH-1]};
    assign div_ge     = (div_shift >= {1'b0, opd_q});
    assign div_diff   = div_shift[WIDTH-1:0] - opd_q;
    assign div_acc_nx = div_ge ? div_diff : div_shift[WIDTH-1:0];
    assign div_lo_nx  = {lo_q[WIDTH-2:0], div_ge};

    assign iter_acc = is_div ? div_acc_nx : mul_acc_nx;
    assign iter_lo  = is_div ? div_lo_nx  : mul_lo_nx;

    // MUL and DIVU read the low/quotient register; MULHU and REMU read the high/remainder one.
    assign final_result = op_q[0] ? iter_acc : iter_lo;

    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        acc_d    = acc_q;
        lo_d     = lo_q;
        opd_d    = opd_q;
        result_d = result_q;

        unique case (state_q)
            S_IDLE: begin
                if (start_i && !flush_i) begin
                    state_d = S_BUSY;
                    cnt_d   = '0;
                    op_d    = op_e'(op_i);
                    acc_d   = '0;
                    lo_d    = op_i[1] ? src_a_i : src_b_i;
                    opd_d   = op_i[1] ? src_b_i : src_a_i;
                end
            end
            S_BUSY: begin
                if (flush_i) begin
                    state_d = S_IDLE;
                end else begin
                    acc_d = iter_acc;
                    lo_d  = iter_lo;
                    cnt_d = cnt_q + 1'b1;
                    if (last_iter) begin
                        state_d  = S_DONE;
                        result_d = final_result;
                    end
                end
            end
            S_DONE: begin
                // The finishing instruction still drives start_i here; it must not retrigger.
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            op_q     <= OP_MUL;
            acc_q    <= '0;
            lo_q     <= '0;
            opd_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            acc_q    <= acc_d;
            lo_q     <= lo_d;
            opd_q    <= opd_d;
            result_q <= result_d;
        end
    end

    assign busy_o   = (state_q == S_BUSY);
    assign done_o   = (state_q == S_DONE);
    assign result_o = result_q;
    assign stall_o  = rst && (((state_q == S_IDLE) && start_i && !flush_i) || (state_q == S_BUSY));

endmodule

// File: tb/tb_ex_muldiv_sequencer.sv
// Self-checking bench for ex_muldiv_sequencer: directed scenarios plus randomized ops
// compared against an arithmetic reference model.
module tb_ex_muldiv_sequencer;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic [1:0]   op = 2'b00;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         flush = 1'b0;
    logic         stall_o, busy_o, done_o;
    logic [W-1:0] result_o;

    int           vectors = 0;
    int           miscompares = 0;
    logic [W-1:0] last_result = '0;

    ex_muldiv_sequencer #(.WIDTH(W), .CNT_W(5)) dut (
        .clk      (clk),
        .rst      (rst),
        .start_i  (start),
        .op_i     (op),
        .src_a_i  (a),
        .src_b_i  (b),
        .flush_i  (flush),
        .stall_o  (stall_o),
        .busy_o   (busy_o),
        .done_o   (done_o),
        .result_o (result_o)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] ref_model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        logic [2*W-1:0] p;
        p = {{W{1'b0}}, x} * {{W{1'b0}}, y};
        case (o)
            2'b00:   return p[W-1:0];
            2'b01:   return p[2*W-1:W];
            2'b10:   return (y == 0) ? {W{1'b1}} : x / y;
            default: return (y == 0) ? x : x % y;
        endcase
    endfunction

    // Runs one op from its start cycle T0 through DONE at T0+W+1, scrambling the
    // operand inputs while busy. Leaves start high during DONE.
    task automatic do_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic [W-1:0] exp, input bit same_cycle, input bit flush_done);
        int bad;
        if (!same_cycle) @(negedge clk);
        start = 1'b1; flush = 1'b0; op = o; a = x; b = y;
        #1;
        vectors++;
        if (stall_o !== 1'b1 || busy_o !== 1'b0 || done_o !== 1'b0) begin
            miscompares++;
            $display("FAIL accept op=%0d: stall=%b busy=%b done=%b, want 1 0 0", o, stall_o, busy_o, done_o);
        end
        bad = 0;
        for (int k = 1; k <= W + 1; k++) begin
            @(negedge clk);
            if (k <= W) begin
                a = $urandom; b = $urandom; op = 2'($urandom);
            end else begin
                flush = flush_done;
            end
            #1;
            if (stall_o !== 1'(k <= W) || busy_o !== 1'(k <= W) || done_o !== 1'(k == W + 1)) bad++;
            if (k <= W && result_o !== last_result) bad++;
        end
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL timing op=%0d: %0d bad cycles, want 0", o, bad);
        end
        vectors++;
        if (result_o !== exp) begin
            miscompares++;
            $display("FAIL result op=%0d a=%h b=%h: got %h, want %h", o, x, y, result_o, exp);
        end
        last_result = exp;
    endtask

    task automatic go_idle();
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        #1;
        vectors++;
        if (stall_o !== 1'b0 || busy_o !== 1'b0 || done_o !== 1'b0 || result_o !== last_result) begin
            miscompares++;
            $display("FAIL idle: stall=%b busy=%b done=%b result=%h, want 0 0 0 %h",
                     stall_o, busy_o, done_o, result_o, last_result);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        start = 1'b1;
        #1;
        vectors++;
        if (stall_o !== 1'b0 || busy_o !== 1'b0 || done_o !== 1'b0 || result_o !== '0) begin
            miscompares++;
            $display("FAIL reset: stall=%b busy=%b done=%b result=%h, want all 0", stall_o, busy_o, done_o, result_o);
        end
        @(negedge clk);
        rst = 1'b1; start = 1'b0;
        go_idle();
    endtask

    task automatic test_mul_basic();
        do_op(2'b00, 32'd7, 32'd6, 32'h0000_002A, 1'b0, 1'b0);
        go_idle();
    endtask

    task automatic test_mulhu();
        do_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 1'b0);
        go_idle();
        do_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        go_idle();
    endtask

    task automatic test_back_to_back();
        do_op(2'b10, 32'd100, 32'd7, 32'h0000_000E, 1'b0, 1'b0);
        do_op(2'b11, 32'd100, 32'd7, 32'h0000_0002, 1'b0, 1'b0);
        go_idle();
    endtask

    task automatic test_div_zero();
        do_op(2'b10, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 1'b0, 1'b0);
        do_op(2'b11, 32'h1234_5678, 32'd0, 32'h1234_5678, 1'b0, 1'b0);
        go_idle();
    endtask

    task automatic test_flush();
        int bad;
        @(negedge clk);
        start = 1'b1; flush = 1'b0; op = 2'b00; a = 32'd9; b = 32'd9;
        bad = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k == 10) flush = 1'b1;
            #1;
            if (busy_o !== 1'b1 || stall_o !== 1'b1 || done_o !== 1'b0) bad++;
        end
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL flush_busy_pre: %0d bad cycles, want 0", bad);
        end
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        #1;
        vectors++;
        if (stall_o !== 1'b0 || busy_o !== 1'b0 || done_o !== 1'b0 || result_o !== last_result) begin
            miscompares++;
            $display("FAIL flush_busy: stall=%b busy=%b done=%b result=%h, want 0 0 0 %h",
                     stall_o, busy_o, done_o, result_o, last_result);
        end
        do_op(2'b00, 32'd3, 32'd5, 32'h0000_000F, 1'b1, 1'b0);
        @(negedge clk);
        start = 1'b1; flush = 1'b1;
        #1;
        vectors++;
        if (stall_o !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_idle_stall: got %b, want 0", stall_o);
        end
        go_idle();
    endtask

    task automatic test_flush_done();
        do_op(2'b10, 32'd1000, 32'd10, 32'd100, 1'b0, 1'b1);
        go_idle();
    endtask

    task automatic test_start_held();
        int dones;
        do_op(2'b01, 32'h8000_0000, 32'd4, 32'h0000_0002, 1'b0, 1'b0);
        dones = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            start = 1'b0;
            #1;
            if (done_o !== 1'b0 || busy_o !== 1'b0) dones++;
        end
        vectors++;
        if (dones != 0) begin
            miscompares++;
            $display("FAIL start_held: %0d cycles busy/done after DONE, want 0", dones);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        start = 1'b1; op = 2'b00; a = 32'd7; b = 32'd6;
        for (int k = 1; k <= 5; k++) @(negedge clk);
        #1;
        rst = 1'b0;
        #1;
        vectors++;
        if (stall_o !== 1'b0 || busy_o !== 1'b0 || done_o !== 1'b0 || result_o !== '0) begin
            miscompares++;
            $display("FAIL reset_mid: stall=%b busy=%b done=%b result=%h, want all 0", stall_o, busy_o, done_o, result_o);
        end
        last_result = '0;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        go_idle();
        go_idle();
    endtask

    task automatic test_random();
        logic [1:0]   o;
        logic [W-1:0] x, y;
        for (int n = 0; n < 40; n++) begin
            o = 2'($urandom_range(0, 3));
            x = $urandom;
            if ($urandom_range(0, 7) == 0)      y = '0;
            else if ($urandom_range(0, 1) == 1) y = $urandom;
            else                                y = W'($urandom_range(1, 255));
            do_op(o, x, y, ref_model(o, x, y), 1'b0, $urandom_range(0, 3) == 0);
            if ($urandom_range(0, 1) == 1) go_idle();
        end
        go_idle();
    endtask

    initial begin
        test_reset();
        test_mul_basic();
        test_mulhu();
        test_back_to_back();
        test_div_zero();
        test_flush();
        test_flush_done();
        test_start_held();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
